// File: rtl/datapath_core.sv
// Accumulator datapath: shared bus, register file with load/inc/clear, small ALU,
// and a run/halt cycle counter that stops on end_op.
module datapath_core #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [12:0]       write_en,
    input  logic [3:0]        bus_ld,
    input  logic [3:0]        alu_mode,
    input  logic [1:0]        inc,
    input  logic [2:0]        clr,
    input  logic              dm_wr,
    input  logic              im_wr,
    input  logic              end_op,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [ADDR_W-1:0] dm_addr_b,
    output logic [DATA_W-1:0] wdata,
    output logic              dm_we,
    output logic              im_we,
    output logic [7:0]        ir,
    output logic              z,
    output logic              done,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic {StRun, StHalt} state_e;

    logic [ADDR_W-1:0] arb_q, arb_d, ar_q, ar_d, pc_q, pc_d;
    logic [DATA_W-1:0] dr_q, dr_d, r_q, r_d, tr_q, tr_d, ac_q, ac_d;
    logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d, ri_q, ri_d, rj_q, rj_d, rk_q, rk_d;
    logic [7:0]        ir_q, ir_d;
    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic [31:0]       cnt_q, cnt_d;

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] alu_res;

    always_comb begin
        pc_ext = '0;
        pc_ext[ADDR_W-1:0] = pc_q;
    end

    always_comb begin
        case (bus_ld)
            4'd0:    bus = im_rdata;
            4'd1:    bus = dm_rdata;
            4'd2:    bus = pc_ext;
            4'd3:    bus = dr_q;
            4'd4:    bus = r_q;
            4'd5:    bus = ac_q;
            4'd6:    bus = tr_q;
            4'd7:    bus = r1_q;
            4'd8:    bus = r2_q;
            4'd9:    bus = ri_q;
            4'd10:   bus = rj_q;
            4'd11:   bus = rk_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        case (alu_mode)
            4'b0000: alu_res = ac_q + bus;
            4'b0001: alu_res = ac_q - bus;
            4'b0010: alu_res = ac_q * bus;
            4'b0101: alu_res = bus;
            default: alu_res = ac_q;
        endcase
    end

    // Per register: clear beats increment beats bus load.
    always_comb begin
        arb_d = write_en[12] ? bus[ADDR_W-1:0] : arb_q;
        ar_d  = write_en[11] ? bus[ADDR_W-1:0] : ar_q;
        dr_d  = write_en[9]  ? bus : dr_q;
        ir_d  = write_en[8]  ? bus[7:0] : ir_q;
        r_d   = write_en[7]  ? bus : r_q;
        r1_d  = write_en[4]  ? bus : r1_q;
        r2_d  = write_en[3]  ? bus : r2_q;
        ri_d  = write_en[2]  ? bus : ri_q;
        rj_d  = write_en[1]  ? bus : rj_q;
        rk_d  = write_en[0]  ? bus : rk_q;

        if (clr[0])              pc_d = '0;
        else if (inc == 2'b01)   pc_d = pc_q + ADDR_W'(1);
        else if (write_en[10])   pc_d = bus[ADDR_W-1:0];
        else                     pc_d = pc_q;

        if (clr[1])              tr_d = '0;
        else if (write_en[6])    tr_d = bus;
        else                     tr_d = tr_q;

        if (clr[2])              ac_d = '0;
        else if (inc == 2'b10)   ac_d = ac_q + DATA_W'(1);
        else if (write_en[5])    ac_d = alu_res;
        else                     ac_d = ac_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_q <= '0; ar_q <= '0; pc_q <= '0;
            dr_q  <= '0; ir_q <= '0; r_q  <= '0; tr_q <= '0; ac_q <= '0;
            r1_q  <= '0; r2_q <= '0; ri_q <= '0; rj_q <= '0; rk_q <= '0;
        end else begin
            arb_q <= arb_d; ar_q <= ar_d; pc_q <= pc_d;
            dr_q  <= dr_d;  ir_q <= ir_d; r_q  <= r_d;  tr_q <= tr_d; ac_q <= ac_d;
            r1_q  <= r1_d;  r2_q <= r2_d; ri_q <= ri_d; rj_q <= rj_d; rk_q <= rk_d;
        end
    end

    // The counter saturates; the end_op cycle itself is counted.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        if (state_q == StRun) begin
            if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
            if (end_op) begin
                state_d = StHalt;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign im_addr   = pc_q;
    assign dm_addr   = ar_q;
    assign dm_addr_b = arb_q;
    assign wdata     = bus;
    assign dm_we     = dm_wr;
    assign im_we     = im_wr;
    assign ir        = ir_q;
    assign z         = (ac_q == '0);
    assign done      = done_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_datapath_core.sv
// Bench for datapath_core: directed vector table, halt/reset sequences and
// random traffic checked against an array-based reference model.
module tb_datapath_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] write_en = '0;
    logic [3:0]  bus_ld = '0, alu_mode = '0;
    logic [1:0]  inc = '0;
    logic [2:0]  clr = '0;
    logic        dm_wr = 1'b0, im_wr = 1'b0, end_op = 1'b0;
    logic [15:0] im_rdata = '0, dm_rdata = '0;
    logic [7:0]  im_addr, dm_addr, dm_addr_b, ir;
    logic [15:0] wdata;
    logic        dm_we, im_we, z, done;
    logic [31:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    datapath_core #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .bus_ld(bus_ld), .alu_mode(alu_mode),
        .inc(inc), .clr(clr), .dm_wr(dm_wr), .im_wr(im_wr), .end_op(end_op),
        .im_rdata(im_rdata), .dm_rdata(dm_rdata), .im_addr(im_addr), .dm_addr(dm_addr),
        .dm_addr_b(dm_addr_b), .wdata(wdata), .dm_we(dm_we), .im_we(im_we), .ir(ir),
        .z(z), .done(done), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Model: index = write_en bit (12 ARB, 11 AR, 10 PC, 9 DR, 8 IR, 7 R, 6 TR, 5 AC, ...)
    logic [15:0] m_reg [13];
    logic [31:0] m_cnt;
    logic        m_halt;

    function automatic logic [15:0] mask_of(int i);
        return (i == 12 || i == 11 || i == 10 || i == 8) ? 16'h00FF : 16'hFFFF;
    endfunction

    function automatic logic [15:0] mbus();
        case (bus_ld)
            4'd0:  return im_rdata;
            4'd1:  return dm_rdata;
            4'd2:  return m_reg[10];
            4'd3:  return m_reg[9];
            4'd4:  return m_reg[7];
            4'd5:  return m_reg[5];
            4'd6:  return m_reg[6];
            4'd7:  return m_reg[4];
            4'd8:  return m_reg[3];
            4'd9:  return m_reg[2];
            4'd10: return m_reg[1];
            4'd11: return m_reg[0];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 13; i++) m_reg[i] = '0;
        m_cnt  = '0;
        m_halt = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] b;
        logic [15:0] nxt [13];
        logic [31:0] prod;
        b = mbus();
        for (int i = 0; i < 13; i++) nxt[i] = m_reg[i];
        for (int i = 0; i < 13; i++) if (write_en[i]) nxt[i] = b & mask_of(i);
        if (write_en[5]) begin
            prod = 32'(m_reg[5]) * 32'(b);
            case (alu_mode)
                4'b0000: nxt[5] = m_reg[5] + b;
                4'b0001: nxt[5] = m_reg[5] - b;
                4'b0010: nxt[5] = prod[15:0];
                4'b0101: nxt[5] = b;
                default: nxt[5] = m_reg[5];
            endcase
        end
        if (inc == 2'b01) nxt[10] = (m_reg[10] + 16'd1) & 16'h00FF;
        if (inc == 2'b10) nxt[5] = m_reg[5] + 16'd1;
        if (clr[2]) nxt[5] = '0;
        if (clr[1]) nxt[6] = '0;
        if (clr[0]) nxt[10] = '0;
        for (int i = 0; i < 13; i++) m_reg[i] = nxt[i];
        if (!m_halt) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (end_op) m_halt = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs (just after a negedge) and check the combinational outputs.
    task automatic apply(input logic [12:0] we, input logic [3:0] bl, input logic [3:0] alu,
                         input logic [1:0] in, input logic [2:0] cl, input logic [15:0] im,
                         input logic [15:0] dm, input logic eop, input logic dw, input logic iw);
        write_en = we; bus_ld = bl; alu_mode = alu; inc = in; clr = cl;
        im_rdata = im; dm_rdata = dm; end_op = eop; dm_wr = dw; im_wr = iw;
        #1;
        check("wdata", 32'(wdata), 32'(mbus()));
        check("dm_we", 32'(dm_we), 32'(dw));
        check("im_we", 32'(im_we), 32'(iw));
    endtask

    task automatic clock();
        @(posedge clk);
        model_step();
        #1;
        check("im_addr", 32'(im_addr), 32'(m_reg[10]));
        check("dm_addr", 32'(dm_addr), 32'(m_reg[11]));
        check("dm_addr_b", 32'(dm_addr_b), 32'(m_reg[12]));
        check("ir", 32'(ir), 32'(m_reg[8]));
        check("z", 32'(z), 32'(m_reg[5] == 16'h0));
        check("done", 32'(done), 32'(m_halt));
        check("cycle_cnt", cycle_cnt, m_cnt);
        @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] bl, input logic eop);
        apply(13'h0, bl, 4'h0, 2'b00, 3'b000, 16'h0, 16'h0, eop, 1'b0, 1'b0);
        clock();
    endtask

    typedef struct {
        logic [12:0] we;
        logic [3:0]  bl;
        logic [3:0]  alu;
        logic [1:0]  inc;
        logic [2:0]  clr;
        logic [15:0] im;
        logic [15:0] dm;
        logic [15:0] exp_bus;
        logic        exp_z;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [12:0] we, input logic [3:0] bl, input logic [3:0] alu,
                       input logic [1:0] in, input logic [2:0] cl, input logic [15:0] im,
                       input logic [15:0] dm, input logic [15:0] eb, input logic ez);
        vec_t v;
        v.we = we; v.bl = bl; v.alu = alu; v.inc = in; v.clr = cl;
        v.im = im; v.dm = dm; v.exp_bus = eb; v.exp_z = ez;
        tbl.push_back(v);
    endtask

    localparam logic [12:0] WE_PC = 13'h0400, WE_DR = 13'h0200, WE_IR = 13'h0100;
    localparam logic [12:0] WE_R = 13'h0080, WE_TR = 13'h0040, WE_AC = 13'h0020;
    localparam logic [12:0] WE_R1 = 13'h0010;

    initial begin
        logic [31:0] r;
        logic [3:0]  alu_pick [5];
        alu_pick[0] = 4'b0000; alu_pick[1] = 4'b0001; alu_pick[2] = 4'b0010;
        alu_pick[3] = 4'b0101; alu_pick[4] = 4'b1110;

        //   we           bl  alu  inc    clr     im       dm       exp_bus  z
        add(13'h0,        5,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0000, 1);
        add(WE_AC,        1,  5,   2'b00, 3'b000, 16'h0,   16'h0005, 16'h0005, 1);
        add(WE_TR,        1,  0,   2'b00, 3'b000, 16'h0,   16'h0003, 16'h0003, 0);
        add(WE_AC,        6,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0003, 0);
        add(13'h0,        5,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0008, 0);
        add(WE_AC,        1,  5,   2'b00, 3'b000, 16'h0,   16'hFFFF, 16'hFFFF, 0);
        add(13'h0,        5,  0,   2'b10, 3'b000, 16'h0,   16'h0,   16'hFFFF, 0);
        add(13'h0,        5,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0000, 1);
        add(WE_PC,        1,  0,   2'b00, 3'b000, 16'h0,   16'h00FF, 16'h00FF, 1);
        add(13'h0,        2,  0,   2'b01, 3'b000, 16'h0,   16'h0,   16'h00FF, 1);
        add(13'h0,        2,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0000, 1);
        add(WE_AC,        1,  5,   2'b00, 3'b000, 16'h0,   16'h1111, 16'h1111, 1);
        add(WE_AC,        1,  5,   2'b10, 3'b100, 16'h0,   16'h2222, 16'h2222, 0);
        add(13'h0,        5,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0000, 1);
        add(WE_PC,        1,  0,   2'b00, 3'b000, 16'h0,   16'h0040, 16'h0040, 1);
        add(13'h0,        2,  0,   2'b01, 3'b001, 16'h0,   16'h0,   16'h0040, 1);
        add(13'h0,        2,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0000, 1);
        add(WE_AC,        1,  5,   2'b00, 3'b000, 16'h0,   16'h0100, 16'h0100, 1);
        add(WE_R,         1,  0,   2'b00, 3'b000, 16'h0,   16'h0100, 16'h0100, 0);
        add(WE_AC,        4,  2,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0100, 0);
        add(13'h0,        5,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0000, 1);
        add(WE_AC,        1,  5,   2'b00, 3'b000, 16'h0,   16'h0002, 16'h0002, 1);
        add(WE_R1,        1,  0,   2'b00, 3'b000, 16'h0,   16'h0003, 16'h0003, 0);
        add(WE_AC,        7,  1,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0003, 0);
        add(13'h0,        5,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'hFFFF, 0);
        add(WE_AC,        1,  7,   2'b00, 3'b000, 16'h0,   16'h1234, 16'h1234, 0);
        add(13'h0,        5,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'hFFFF, 0);
        add(WE_TR,        1,  0,   2'b00, 3'b000, 16'h0,   16'h0007, 16'h0007, 0);
        add(WE_AC|WE_TR,  6,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0007, 0);
        add(13'h0,        5,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0006, 0);
        add(13'h0,        6,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0007, 0);
        add(13'h0,        12, 0,   2'b00, 3'b000, 16'hBEEF, 16'hBEEF, 16'h0000, 0);
        add(13'h0,        15, 0,   2'b00, 3'b000, 16'hBEEF, 16'hBEEF, 16'h0000, 0);
        add(WE_IR|WE_DR,  0,  0,   2'b00, 3'b000, 16'hABCD, 16'h0,  16'hABCD, 0);
        add(13'h0,        3,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'hABCD, 0);
        add(WE_TR,        1,  0,   2'b00, 3'b010, 16'h0,   16'h0009, 16'h0009, 0);
        add(13'h0,        6,  0,   2'b00, 3'b000, 16'h0,   16'h0,   16'h0000, 0);

        // Reset state
        model_reset();
        #1 rst = 1'b1;
        bus_ld = 4'd5;
        @(negedge clk);
        check("rst_wdata", 32'(wdata), 32'h0);
        check("rst_z", 32'(z), 32'h1);
        check("rst_done", 32'(done), 32'h0);
        check("rst_cnt", cycle_cnt, 32'h0);
        check("rst_pc", 32'(im_addr), 32'h0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            apply(tbl[k].we, tbl[k].bl, tbl[k].alu, tbl[k].inc, tbl[k].clr, tbl[k].im,
                  tbl[k].dm, 1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d_bus", k), 32'(wdata), 32'(tbl[k].exp_bus));
            check($sformatf("vec%0d_z", k), 32'(z), 32'(tbl[k].exp_z));
            clock();
        end
        check("vec_cnt", cycle_cnt, 32'(tbl.size()));

        // Random traffic in RUN (end_op rare, so some runs may halt partway)
        for (int n = 0; n < 300; n++) begin
            logic [12:0] we;
            logic [2:0]  cl;
            r = $urandom;
            we = (r[31:30] == 2'b00) ? 13'h0 : r[12:0];
            cl = (r[29:27] == 3'b000) ? r[26:24] : 3'b000;
            apply(we, r[16:13], alu_pick[$urandom_range(0, 4)], r[18:17], cl,
                  16'($urandom), 16'($urandom), ($urandom_range(0, 199) == 0),
                  r[19], r[20]);
            clock();
        end

        // Async reset between edges with AC loaded and done set
        apply(WE_AC, 1, 5, 2'b00, 3'b000, 16'h0, 16'h1234, 1'b1, 1'b0, 1'b0);
        clock();
        apply(13'h0, 5, 0, 2'b00, 3'b000, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_ac", 32'(wdata), 32'h1234);
        check("pre_rst_done", 32'(done), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("arst_ac", 32'(wdata), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_cnt", cycle_cnt, 32'h0);
        check("arst_z", 32'(z), 32'h1);
        write_en = WE_AC; bus_ld = 4'd1; alu_mode = 4'b0101; dm_rdata = 16'h5555;
        @(posedge clk);
        #1;
        write_en = '0; bus_ld = 4'd5;
        #1;
        check("rst_hold_ac", 32'(wdata), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Halt: end_op on the 10th cycle after reset
        for (int n = 0; n < 9; n++) idle(4'd5, 1'b0);
        check("pre_halt_done", 32'(done), 32'h0);
        idle(4'd5, 1'b1);
        check("halt_done", 32'(done), 32'h1);
        check("halt_cnt", cycle_cnt, 32'd10);
        for (int n = 0; n < 20; n++) idle(4'd5, 1'b0);
        check("halt_hold_done", 32'(done), 32'h1);
        check("halt_hold_cnt", cycle_cnt, 32'd10);
        idle(4'd5, 1'b1);
        check("halt_2nd_cnt", cycle_cnt, 32'd10);

        // Loads stay functional in HALT
        apply(WE_AC, 1, 5, 2'b00, 3'b000, 16'h0, 16'h4321, 1'b0, 1'b0, 1'b0);
        clock();
        apply(13'h0, 5, 0, 2'b00, 3'b000, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("halt_load_ac", 32'(wdata), 32'h4321);
        clock();
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            apply(r[12:0], r[16:13], alu_pick[$urandom_range(0, 4)], r[18:17],
                  (r[29:27] == 3'b000) ? r[26:24] : 3'b000,
                  16'($urandom), 16'($urandom), r[21], r[19], r[20]);
            clock();
        end
        check("halt_end_cnt", cycle_cnt, 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
